// File: rtl/dla_edge_handshake_pkg.sv
// Shared types for the two-phase edge handshake responder.
package dla_edge_handshake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } edge_resp_state_t;

endpackage

// File: rtl/dla_edge_handshake_responder.sv
// Destination end of a toggle handshake: captures payload SETTLE_CYCLES after a request edge,
// offers it as valid/ready (held until i_ready), and flips the ack toggle on acceptance.
module dla_edge_handshake_responder
    import dla_edge_handshake_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   i_sync_reset,
    input  logic                   i_req_toggle,
    input  logic [DATA_WIDTH-1:0]  i_req_data,
    output logic                   o_ack_toggle,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    input  logic                   i_ready,
    output logic                   o_busy,
    output logic                   o_protocol_error,
    output logic [COUNT_WIDTH-1:0] o_event_count
);

    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    edge_resp_state_t        state_q, state_d;
    logic                    req_prev_q, req_prev_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic [COUNT_WIDTH-1:0]  evt_q, evt_d;
    logic [CNT_W-1:0]        settle_q, settle_d;
    logic                    edge_seen;

    assign edge_seen = (i_req_toggle != req_prev_q);

    always_comb begin
        state_d    = state_q;
        req_prev_d = req_prev_q;
        ack_d      = ack_q;
        data_d     = data_q;
        err_d      = err_q;
        evt_d      = evt_q;
        settle_d   = settle_q;
        case (state_q)
            IDLE: begin
                if (edge_seen) begin
                    req_prev_d = i_req_toggle;
                    if (SETTLE_CYCLES == 0) begin
                        data_d  = i_req_data;
                        state_d = VALID;
                    end else begin
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // An early edge is flagged but left unconsumed; IDLE picks it up later.
                if (edge_seen) err_d = 1'b1;
                if (settle_q == '0) begin
                    data_d  = i_req_data;
                    state_d = VALID;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            VALID: begin
                if (edge_seen) err_d = 1'b1;
                if (i_ready) begin
                    ack_d   = req_prev_q;
                    evt_d   = (evt_q == '1) ? evt_q : evt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_sync_reset) begin
            state_q    <= IDLE;
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            evt_q      <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req_prev_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            err_q      <= err_d;
            evt_q      <= evt_d;
            settle_q   <= settle_d;
        end
    end

    assign o_ack_toggle     = ack_q;
    assign o_valid          = (state_q == VALID);
    assign o_busy           = (state_q != IDLE);
    assign o_data           = data_q;
    assign o_protocol_error = err_q;
    assign o_event_count    = evt_q;

endmodule

// File: tb/tb_dla_edge_handshake_responder.sv
// Bench: instance 0 has SETTLE_CYCLES=2/COUNT_WIDTH=2, instance 1 has SETTLE_CYCLES=0/COUNT_WIDTH=16.
module tb_dla_edge_handshake_responder;

    logic       clk = 1'b0;
    logic       rst [2];
    logic       tog [2];
    logic [7:0] dat [2];
    logic       rdy [2];

    logic       valid_o [2];
    logic [7:0] data_o  [2];
    logic       ack_o   [2];
    logic       busy_o  [2];
    logic       err_o   [2];
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    dla_edge_handshake_responder #(.DATA_WIDTH(8), .SETTLE_CYCLES(2), .COUNT_WIDTH(2)) u_dut_a (
        .clk(clk), .i_sync_reset(rst[0]), .i_req_toggle(tog[0]), .i_req_data(dat[0]),
        .o_ack_toggle(ack_o[0]), .o_valid(valid_o[0]), .o_data(data_o[0]), .i_ready(rdy[0]),
        .o_busy(busy_o[0]), .o_protocol_error(err_o[0]), .o_event_count(cnt_a)
    );

    dla_edge_handshake_responder #(.DATA_WIDTH(8), .SETTLE_CYCLES(0), .COUNT_WIDTH(16)) u_dut_b (
        .clk(clk), .i_sync_reset(rst[1]), .i_req_toggle(tog[1]), .i_req_data(dat[1]),
        .o_ack_toggle(ack_o[1]), .o_valid(valid_o[1]), .o_data(data_o[1]), .i_ready(rdy[1]),
        .o_busy(busy_o[1]), .o_protocol_error(err_o[1]), .o_event_count(cnt_b)
    );

    // Transaction-level model: a request is "pending" from its edge until accepted;
    // payload is sampled at edge+S and offered from the cycle after that.
    typedef struct {
        bit       pending;
        bit       prev;
        bit       ack;
        bit       err;
        bit       valid;
        bit [7:0] data;
        int       cnt;
        int       cap;
    } model_t;

    model_t m [2];

    function automatic model_t mstep(model_t mi, int s, int cmax, bit r, bit tg,
                                     bit [7:0] d, bit rd, int c);
        model_t mo = mi;
        if (r) begin
            mo = '{default: 0};
            return mo;
        end
        if (!mo.pending) begin
            if (tg != mo.prev) begin
                mo.prev    = tg;
                mo.pending = 1'b1;
                mo.cap     = c + s;
                if (s == 0) mo.data = d;
            end
        end else begin
            if (tg != mo.prev) mo.err = 1'b1;
            if (s > 0 && c == mo.cap) begin
                mo.data = d;
            end else if (c > mo.cap && rd) begin
                mo.ack     = mo.prev;
                mo.pending = 1'b0;
                if (mo.cnt < cmax) mo.cnt = mo.cnt + 1;
            end
        end
        mo.valid = mo.pending && (c >= mo.cap);
        return mo;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] got_vec(input int k);
        logic [15:0] c16;
        c16 = (k == 0) ? 16'(cnt_a) : cnt_b;
        return {4'b0, valid_o[k], data_o[k], ack_o[k], busy_o[k], err_o[k], c16};
    endfunction

    function automatic logic [31:0] exp_vec(input int k);
        return {4'b0, m[k].valid, m[k].data, m[k].ack, m[k].pending, m[k].err, 16'(m[k].cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        m[0] = mstep(m[0], 2, 3,     rst[0], tog[0], dat[0], rdy[0], cyc);
        m[1] = mstep(m[1], 0, 65535, rst[1], tog[1], dat[1], rdy[1], cyc);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("model dut%0d cyc%0d", k, cyc), got_vec(k), exp_vec(k));
    endtask

    // One full transfer on instance 0 with i_ready high; returns once the ack flips.
    task automatic xfer_a(input logic [7:0] d);
        logic a0;
        bit   done;
        a0      = ack_o[0];
        done    = 1'b0;
        tog[0]  = ~tog[0];
        dat[0]  = d;
        rdy[0]  = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            tick();
            if (ack_o[0] != a0) done = 1'b1;
        end
        chk("xfer_a ack flipped", {31'b0, done}, 32'd1);
    endtask

    typedef struct {
        bit       rst;
        bit       tog;
        bit [7:0] d;
        bit       rdy;
        bit       e_valid;
        bit [7:0] e_data;
        bit       e_ack;
        bit       e_busy;
        bit [1:0] e_cnt;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m[k] = '{default: 0};
            rst[k] = 1'b1; tog[k] = 1'b0; dat[k] = 8'h00; rdy[k] = 1'b0;
        end

        // Basic transfer then start of a held transfer (instance 0, settle=2).
        tbl[0] = '{1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 2'd0};
        tbl[1] = '{0, 1, 8'hA5, 1,  0, 8'h00, 0, 1, 2'd0};
        tbl[2] = '{0, 1, 8'hA5, 1,  0, 8'h00, 0, 1, 2'd0};
        tbl[3] = '{0, 1, 8'hA5, 1,  1, 8'hA5, 0, 1, 2'd0};
        tbl[4] = '{0, 1, 8'hA5, 1,  0, 8'hA5, 1, 0, 2'd1};
        tbl[5] = '{0, 1, 8'hA5, 1,  0, 8'hA5, 1, 0, 2'd1};
        tbl[6] = '{0, 0, 8'h3C, 0,  0, 8'hA5, 1, 1, 2'd1};
        tbl[7] = '{0, 0, 8'h3C, 0,  0, 8'hA5, 1, 1, 2'd1};
        tbl[8] = '{0, 0, 8'h3C, 0,  1, 8'h3C, 1, 1, 2'd1};

        for (int i = 0; i < 9; i++) begin
            rst[0] = tbl[i].rst; tog[0] = tbl[i].tog; dat[0] = tbl[i].d; rdy[0] = tbl[i].rdy;
            tick();
            chk($sformatf("table row%0d", i),
                {19'b0, valid_o[0], data_o[0], ack_o[0], busy_o[0], cnt_a},
                {19'b0, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ack, tbl[i].e_busy, tbl[i].e_cnt});
        end

        // Held in VALID with i_ready low.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold cyc%0d", i), {22'b0, valid_o[0], data_o[0], ack_o[0]}, {22'b0, 1'b1, 8'h3C, 1'b1});
        end
        rdy[0] = 1'b1;
        tick();
        chk("hold release ack", {31'b0, ack_o[0]}, 32'd0);
        chk("hold release cnt", {30'b0, cnt_a}, 32'd2);

        // Double toggle during SETTLE: error, but no extra transfer.
        tog[0] = 1'b1; dat[0] = 8'h77;
        tick();
        tog[0] = 1'b0;
        tick();
        chk("settle err set", {31'b0, err_o[0]}, 32'd1);
        tog[0] = 1'b1;
        tick();
        chk("settle captured", {23'b0, valid_o[0], data_o[0]}, {23'b0, 1'b1, 8'h77});
        tick();
        chk("settle done ack", {31'b0, ack_o[0]}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("no extra xfer %0d", i), {30'b0, busy_o[0], err_o[0]}, {30'b0, 2'b01});
        end

        // Two more accepted transfers: five in total, counter saturates at 3.
        xfer_a(8'h11);
        xfer_a(8'h22);
        tick();
        chk("count saturated", {30'b0, cnt_a}, 32'd3);

        // Reset while VALID, then toggle already high after release is serviced.
        tog[0] = ~tog[0]; dat[0] = 8'h5A; rdy[0] = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre-reset valid", {31'b0, valid_o[0]}, 32'd1);
        tog[0] = 1'b1; rst[0] = 1'b1;
        tick();
        chk("reset outputs", {20'b0, valid_o[0], data_o[0], ack_o[0], busy_o[0], err_o[0], cnt_a},
            32'd0);
        rst[0] = 1'b0; rdy[0] = 1'b1; dat[0] = 8'hC3;
        begin
            bit done = 1'b0;
            for (int i = 0; i < 8 && !done; i++) begin
                tick();
                if (ack_o[0]) done = 1'b1;
            end
            chk("post-reset serviced", {31'b0, done}, 32'd1);
        end
        chk("post-reset data/cnt", {22'b0, data_o[0], cnt_a}, {22'b0, 8'hC3, 2'd1});

        // Instance 1, settle=0: four back-to-back requests.
        rst[1] = 1'b0;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tog[1] = ~tog[1]; dat[1] = 8'(i); rdy[1] = 1'b1;
            tick();
            chk($sformatf("b2b valid %0d", i), {23'b0, valid_o[1], data_o[1]}, {23'b0, 1'b1, 8'(i)});
            tick();
            chk($sformatf("b2b ack %0d", i), {31'b0, ack_o[1]}, {31'b0, i[0]});
        end
        chk("b2b count", {16'b0, cnt_b}, 32'd4);

        // Random traffic on both instances against the model.
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 79) == 0);
                if ($urandom_range(0, 3) == 0) tog[k] = ~tog[k];
                dat[k] = 8'($urandom);
                rdy[k] = $urandom_range(0, 1) == 1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
